// File: rtl/aes_pkg.sv
// Shared constants, FSM/direction encodings and the CBC mixing helper for aes_cbc_chain.
package aes_pkg;

  localparam int WORD_W = 32;
  localparam int BLK_W  = 4 * WORD_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  typedef enum logic {
    DIR_ENC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  // XOR the chaining value in only when the mode asks for it.
  function automatic logic [BLK_W-1:0] cbc_mix(input logic i_en,
                                               input logic [BLK_W-1:0] i_blk,
                                               input logic [BLK_W-1:0] i_chain);
    return i_en ? (i_blk ^ i_chain) : i_blk;
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// 4x32 shift-in block register: each write pushes a word into the low end, oldest word falls off the top.
// A parallel load (lower priority than a write) lets the owner overwrite the whole block.
module aes_word_packer
  import aes_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_ld,
  input  logic [BLK_W-1:0]  i_ld_blk,
  output logic [BLK_W-1:0]  o_blk
);

  logic [BLK_W-1:0] r_blk;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_blk <= '0;
    end else if (i_wr) begin
      r_blk <= {r_blk[BLK_W-WORD_W-1:0], i_word};
    end else if (i_ld) begin
      r_blk <= i_ld_blk;
    end
  end

  assign o_blk = r_blk;

endmodule

// File: rtl/aes_cbc_chain.sv
// CBC/ECB chaining stage between the register file and the AES core; done follows start by core latency + 3 cycles.
// Writes and starts are dropped while busy. Define AES_CHAIN_AUTO_EN to let each CBC block update the chain register.
module aes_cbc_chain
  import aes_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cbc_en,
  input  logic              in_wr,
  input  logic [WORD_W-1:0] in_word,
  input  logic              iv_wr,
  input  logic [WORD_W-1:0] iv_word,
  input  logic              start_enc,
  input  logic              start_dec,
  input  logic              core_ready,
  output logic              core_start,
  output logic              core_decrypt,
  output logic [BLK_W-1:0]  core_din,
  input  logic [BLK_W-1:0]  core_dout,
  input  logic              core_done,
  output logic [BLK_W-1:0]  result,
  output logic              busy,
  output logic              done
);

  state_e           r_state;
  dir_e             r_dir;
  logic             r_cbc;
  logic             r_busy;
  logic             r_done;
  logic             r_core_start;
  logic             r_core_decrypt;
  logic [BLK_W-1:0] r_src;
  logic [BLK_W-1:0] r_dout;
  logic [BLK_W-1:0] r_core_din;
  logic [BLK_W-1:0] r_result;

  logic             w_in_wr;
  logic             w_iv_wr;
  logic             w_go_enc;
  logic             w_go_dec;
  logic             w_go;
  logic             w_chain_ld;
  logic [BLK_W-1:0] w_chain_ld_blk;
  logic [BLK_W-1:0] w_in_blk;
  logic [BLK_W-1:0] w_chain;

  assign w_in_wr  = in_wr & ~r_busy;
  assign w_iv_wr  = iv_wr & ~r_busy;
  // Encrypt wins when both starts arrive together; no keys means the request is dropped.
  assign w_go_enc = (r_state == IDLE) & start_enc & core_ready;
  assign w_go_dec = (r_state == IDLE) & ~start_enc & start_dec & core_ready;
  assign w_go     = w_go_enc | w_go_dec;

`ifdef AES_CHAIN_AUTO_EN
  assign w_chain_ld     = (r_state == CAPTURE) & r_cbc;
  assign w_chain_ld_blk = (r_dir == DIR_ENC) ? r_dout : r_src;
`else
  assign w_chain_ld     = 1'b0;
  assign w_chain_ld_blk = '0;
`endif

  aes_word_packer u_in_pack (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_ni),
    .i_wr     (w_in_wr),
    .i_word   (in_word),
    .i_ld     (1'b0),
    .i_ld_blk ('0),
    .o_blk    (w_in_blk)
  );

  aes_word_packer u_chain_pack (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_ni),
    .i_wr     (w_iv_wr),
    .i_word   (iv_word),
    .i_ld     (w_chain_ld),
    .i_ld_blk (w_chain_ld_blk),
    .o_blk    (w_chain)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state        <= IDLE;
      r_dir          <= DIR_ENC;
      r_cbc          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_core_start   <= 1'b0;
      r_core_decrypt <= 1'b0;
      r_src          <= '0;
      r_dout         <= '0;
      r_core_din     <= '0;
      r_result       <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_in_wr) r_done <= 1'b0;
          if (w_go) begin
            // Core-facing outputs are registered so they are valid for the whole LAUNCH cycle.
            r_state        <= LAUNCH;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_dir          <= w_go_dec ? DIR_DEC : DIR_ENC;
            r_cbc          <= cbc_en;
            r_src          <= w_in_blk;
            r_core_start   <= 1'b1;
            r_core_decrypt <= w_go_dec;
            r_core_din     <= cbc_mix(w_go_enc & cbc_en, w_in_blk, w_chain);
          end
        end
        LAUNCH: r_state <= WAIT;
        WAIT: begin
          if (core_done) begin
            r_dout  <= core_dout;
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_result <= cbc_mix((r_dir == DIR_DEC) & r_cbc, r_dout, w_chain);
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_start   = r_core_start;
  assign core_decrypt = r_core_decrypt;
  assign core_din     = r_core_din;
  assign result       = r_result;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_aes_cbc_chain.sv
// Directed bench for aes_cbc_chain with a fixed-latency AES core stand-in.
module tb_aes_cbc_chain;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_ni;
  logic         cbc_en;
  logic         in_wr;
  logic [31:0]  in_word;
  logic         iv_wr;
  logic [31:0]  iv_word;
  logic         start_enc;
  logic         start_dec;
  logic         core_ready;
  logic         core_start;
  logic         core_decrypt;
  logic [127:0] core_din;
  logic [127:0] core_dout;
  logic         core_done;
  logic [127:0] result;
  logic         busy;
  logic         done;

  logic         model_done = 1'b0;
  logic         stray_done;
  int           core_lat;
  int           mdl_cnt = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  localparam logic [127:0] IV  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT  = 128'h6BC1BEE22E409F96E93D7E117393172A;
  localparam logic [127:0] CT  = 128'h7649ABAC8119B246CEE98E9B12E9197D;

  always #5 wb_clk_i = ~wb_clk_i;

  aes_cbc_chain dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_ni    (wb_rst_ni),
    .cbc_en       (cbc_en),
    .in_wr        (in_wr),
    .in_word      (in_word),
    .iv_wr        (iv_wr),
    .iv_word      (iv_word),
    .start_enc    (start_enc),
    .start_dec    (start_dec),
    .core_ready   (core_ready),
    .core_start   (core_start),
    .core_decrypt (core_decrypt),
    .core_din     (core_din),
    .core_dout    (core_dout),
    .core_done    (core_done),
    .result       (result),
    .busy         (busy),
    .done         (done)
  );

  // Core stand-in: core_done is high core_lat cycles after the core_start cycle.
  always @(posedge wb_clk_i) begin
    model_done <= 1'b0;
    if (core_start) begin
      mdl_cnt <= core_lat - 1;
      if (core_lat == 1) model_done <= 1'b1;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) model_done <= 1'b1;
    end
  end

  assign core_done = model_done | stray_done;

  task automatic wr_in(input logic [127:0] blk);
    for (int i = 3; i >= 0; i--) begin
      in_word = blk[i*32 +: 32];
      in_wr   = 1'b1;
      @(negedge wb_clk_i);
    end
    in_wr = 1'b0;
  endtask

  task automatic wr_iv(input logic [127:0] blk);
    for (int i = 3; i >= 0; i--) begin
      iv_word = blk[i*32 +: 32];
      iv_wr   = 1'b1;
      @(negedge wb_clk_i);
    end
    iv_wr = 1'b0;
  endtask

  task automatic pulse_start(input logic e, input logic d);
    start_enc = e;
    start_dec = d;
    @(negedge wb_clk_i);
    start_enc = 1'b0;
    start_dec = 1'b0;
  endtask

  // Returns the cycle index (start cycle = 0) at which done is first seen, or -1 on timeout.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge wb_clk_i);
      k++;
    end
    if (done !== 1'b1) k = -1;
  endtask

  task automatic test_reset;
    int k;
    wb_rst_ni = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    n_checks++;
    if ({core_start, core_decrypt, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {core_start, core_decrypt, busy, done});
    end
    n_checks++;
    if (core_din !== 128'h0 || result !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: din %h result %h expected 0", core_din, result);
    end
    core_lat  = 8;
    cbc_en    = 1'b0;
    core_dout = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    wr_in(128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF);
    pulse_start(1'b1, 1'b0);
    repeat (3) @(negedge wb_clk_i);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy_before: got %b expected 1", busy);
    end
    wb_rst_ni = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    n_checks++;
    if ({core_start, core_decrypt, busy, done} !== 4'b0000 || core_din !== 128'h0 || result !== 128'h0) begin
      n_fail++; $display("FAIL reset_midop: ctl %b din %h result %h expected all 0",
                         {core_start, core_decrypt, busy, done}, core_din, result);
    end
    repeat (10) @(negedge wb_clk_i);
    n_checks++;
    if (result !== 128'h0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_late_done: result %h done %b busy %b expected 0 0 0", result, done, busy);
    end
    // The FSM must be back in IDLE: a fresh start is accepted normally.
    core_lat = 2;
    pulse_start(1'b1, 1'b0);
    n_checks++;
    if (core_start !== 1'b1 || core_din !== 128'h0) begin
      n_fail++; $display("FAIL reset_idle_start: core_start %b din %h expected 1 0", core_start, core_din);
    end
    wait_done(1, k);
  endtask

  task automatic test_ecb;
    int k;
    core_lat  = 3;
    cbc_en    = 1'b0;
    wr_iv(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    wr_in(128'h00112233_44556677_8899AABB_CCDDEEFF);
    core_dout = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    pulse_start(1'b1, 1'b0);
    n_checks++;
    if (core_din !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
      n_fail++; $display("FAIL ecb_din: got %h expected 00112233445566778899aabbccddeeff", core_din);
    end
    n_checks++;
    if ({core_start, core_decrypt, busy, done} !== 4'b1010) begin
      n_fail++; $display("FAIL ecb_launch: start/dec/busy/done %b expected 1010", {core_start, core_decrypt, busy, done});
    end
    @(negedge wb_clk_i);
    n_checks++;
    if (core_start !== 1'b0) begin
      n_fail++; $display("FAIL ecb_start_pulse: got %b expected 0", core_start);
    end
    wait_done(2, k);
    n_checks++;
    if (k != 6) begin
      n_fail++; $display("FAIL ecb_latency: got %0d expected 6", k);
    end
    n_checks++;
    if (result !== 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A || busy !== 1'b0) begin
      n_fail++; $display("FAIL ecb_result: got %h busy %b expected 69c4e0d86a7b0430d8cdb78070b4c55a busy 0", result, busy);
    end
  endtask

  task automatic test_cbc;
    int k;
    core_lat = 2;
    cbc_en   = 1'b1;
    wr_iv(IV);
    wr_in(PT);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL cbc_done_clear: got %b expected 0", done);
    end
    core_dout = CT;
    pulse_start(1'b1, 1'b0);
    n_checks++;
    if (core_din !== 128'h6BC0BCE12A459991E134741A7F9E1925) begin
      n_fail++; $display("FAIL cbc_enc_din: got %h expected 6bc0bce12a459991e134741a7f9e1925", core_din);
    end
    wait_done(1, k);
    n_checks++;
    if (k != 5 || result !== CT) begin
      n_fail++; $display("FAIL cbc_enc_result: cycles %0d result %h expected 5 %h", k, result, CT);
    end
    wr_iv(IV);
    wr_in(CT);
    core_dout = 128'h6BC0BCE12A459991E134741A7F9E1925;
    pulse_start(1'b0, 1'b1);
    n_checks++;
    if (core_decrypt !== 1'b1 || core_din !== CT) begin
      n_fail++; $display("FAIL cbc_dec_launch: dec %b din %h expected 1 %h", core_decrypt, core_din, CT);
    end
    wait_done(1, k);
    n_checks++;
    if (k < 0 || result !== PT) begin
      n_fail++; $display("FAIL cbc_dec_result: cycles %0d result %h expected %h", k, result, PT);
    end
  endtask

  task automatic test_start_conflicts;
    int k;
    core_lat  = 3;
    cbc_en    = 1'b0;
    wr_in(128'h01234567_89ABCDEF_FEDCBA98_76543210);
    core_dout = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
    pulse_start(1'b1, 1'b1);
    n_checks++;
    if (core_decrypt !== 1'b0 || core_start !== 1'b1) begin
      n_fail++; $display("FAIL both_starts: dec %b start %b expected 0 1", core_decrypt, core_start);
    end
    wait_done(1, k);
    n_checks++;
    if (k != 6 || result !== 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333) begin
      n_fail++; $display("FAIL both_starts_result: cycles %0d result %h expected 6 aaaa0000bbbb1111cccc2222dddd3333", k, result);
    end
    core_ready = 1'b0;
    pulse_start(1'b1, 1'b0);
    @(negedge wb_clk_i);
    n_checks++;
    if (core_start !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL not_ready: start %b busy %b done %b expected 0 0 1", core_start, busy, done);
    end
    core_ready = 1'b1;
    stray_done = 1'b1;
    @(negedge wb_clk_i);
    stray_done = 1'b0;
    @(negedge wb_clk_i);
    n_checks++;
    if (busy !== 1'b0 || result !== 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333) begin
      n_fail++; $display("FAIL stray_done: busy %b result %h expected 0 aaaa0000bbbb1111cccc2222dddd3333", busy, result);
    end
    core_lat  = 5;
    core_dout = 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;
    wr_in(128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3);
    pulse_start(1'b1, 1'b0);
    @(negedge wb_clk_i);
    in_word   = 32'hDEADDEAD;
    in_wr     = 1'b1;
    start_dec = 1'b1;
    @(negedge wb_clk_i);
    in_wr     = 1'b0;
    start_dec = 1'b0;
    n_checks++;
    if (core_decrypt !== 1'b0 || busy !== 1'b1 || core_din !== 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3) begin
      n_fail++; $display("FAIL wait_ignore: dec %b busy %b din %h expected 0 1 b0b0b0b0b1b1b1b1b2b2b2b2b3b3b3b3",
                         core_decrypt, busy, core_din);
    end
    wait_done(3, k);
    n_checks++;
    if (k != 8) begin
      n_fail++; $display("FAIL wait_ignore_latency: got %0d expected 8", k);
    end
    pulse_start(1'b1, 1'b0);
    n_checks++;
    if (core_din !== 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3) begin
      n_fail++; $display("FAIL wait_ignore_inblk: got %h expected b0b0b0b0b1b1b1b1b2b2b2b2b3b3b3b3", core_din);
    end
    wait_done(1, k);
  endtask

  task automatic test_packing;
    int k;
    core_lat = 1;
    cbc_en   = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_word = 32'(i);
      in_wr   = 1'b1;
      @(negedge wb_clk_i);
    end
    in_wr = 1'b0;
    pulse_start(1'b1, 1'b0);
    n_checks++;
    if (core_din !== 128'h00000002_00000003_00000004_00000005) begin
      n_fail++; $display("FAIL pack_five: got %h expected 00000002000000030000000400000005", core_din);
    end
    wait_done(1, k);
    n_checks++;
    if (k != 4) begin
      n_fail++; $display("FAIL pack_latency: got %0d expected 4", k);
    end
  endtask

  task automatic test_chain_auto;
    int k;
    logic [127:0] exp_din2;
`ifdef AES_CHAIN_AUTO_EN
    exp_din2 = 128'h5A5A5A5A_5A5A5A5A_F0F0F0F0_F0F0F0F0;
`else
    exp_din2 = 128'hFFFEFDFC_04050607_F7F6F5F4_0C0D0E0F;
`endif
    core_lat = 2;
    cbc_en   = 1'b1;
    wr_iv(IV);
    wr_in(128'h11111111_22222222_33333333_44444444);
    core_dout = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    pulse_start(1'b1, 1'b0);
    n_checks++;
    if (core_din !== 128'h11101312_26272425_3B3A3938_48494A4B) begin
      n_fail++; $display("FAIL chain_din1: got %h expected 11101312262724253b3a393848494a4b", core_din);
    end
    wait_done(1, k);
    n_checks++;
    if (k != 5 || result !== 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0) begin
      n_fail++; $display("FAIL chain_result1: cycles %0d result %h expected 5 a5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0", k, result);
    end
    wr_in(128'hFFFFFFFF_00000000_FFFFFFFF_00000000);
    pulse_start(1'b1, 1'b0);
    n_checks++;
    if (core_din !== exp_din2) begin
      n_fail++; $display("FAIL chain_din2: got %h expected %h", core_din, exp_din2);
    end
    wait_done(1, k);
    n_checks++;
    if (k < 0) begin
      n_fail++; $display("FAIL chain_done2: got timeout expected done");
    end
  endtask

  initial begin
    wb_rst_ni  = 1'b0;
    cbc_en     = 1'b0;
    in_wr      = 1'b0;
    in_word    = 32'h0;
    iv_wr      = 1'b0;
    iv_word    = 32'h0;
    start_enc  = 1'b0;
    start_dec  = 1'b0;
    core_ready = 1'b1;
    core_dout  = 128'h0;
    stray_done = 1'b0;
    core_lat   = 3;
    @(negedge wb_clk_i);
    test_reset;
    test_ecb;
    test_cbc;
    test_start_conflicts;
    test_packing;
    test_chain_auto;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_cbc_chain.md
Name: aes_cbc_chain

Overview:
- Block-chaining stage between the Wishbone register file and the AES round core.
- Packs 32-bit data and IV writes into 128-bit blocks.
- Applies CBC XOR before the core for encryption and after it for decryption.
- Keeps the chaining register and holds the 128-bit result plus busy/done status for readback at 0x30–0x3C and status bit 2.

Parameters:
- WORD_W, 32, width of one register-file word; fixed to 32.
- BLK_W, 128, AES block width; must equal 4*WORD_W.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_ni  in  1  synchronous, active-low reset
- cbc_en  in  1  control bit 3; 1 = CBC, 0 = ECB (no XOR)
- in_wr  in  1  one-cycle strobe: shift in_word into input block
- in_word  in  32  data word (write to 0x10)
- iv_wr  in  1  one-cycle strobe: shift iv_word into chain register
- iv_word  in  32  IV word (write to 0x20)
- start_enc  in  1  one-cycle encrypt request (0x04)
- start_dec  in  1  one-cycle decrypt request (0x08)
- core_ready  in  1  round keys valid (status bits 1:0 == 2'b11)
- core_start  out  1  one-cycle pulse to AES core
- core_decrypt  out  1  direction to core, held stable while busy
- core_din  out  128  block presented to core
- core_dout  in  128  core result
- core_done  in  1  one-cycle pulse: core_dout valid
- result  out  128  final block; [127:96] is word read at 0x30
- busy  out  1  operation in flight
- done  out  1  sticky completion flag (status bit 2)

Behaviour:
- Reset (wb_rst_ni=0 at edge) clears the following to zero:
  - in_blk, chain, result, busy, done, core_start, core_decrypt, core_din
  - FSM returns to IDLE
  - An in-flight core operation is abandoned; a later core_done is ignored.
- Packing (both in_blk and chain): on a strobe, reg <= {reg[95:0], word}.
  - The first of 4 writes ends in [127:96].
  - There is no word counter. A 5th write discards the oldest word; fewer than 4 writes leave stale low words.
- in_wr, iv_wr, start_* are ignored while busy=1.
- in_wr or start accepted in IDLE clears done.
- FSM states:
  - IDLE:
    - start_enc & core_ready → LAUNCH, dir=enc.
    - Else start_dec & core_ready → LAUNCH, dir=dec. When both starts are asserted, encrypt wins.
    - A start with core_ready=0 is dropped; done is unchanged.
    - On entry to LAUNCH, busy=1 and in_blk is latched into src.
  - LAUNCH (1 cycle):
    - core_start=1, core_decrypt=dir.
    - core_din = enc&cbc_en ? src^chain : src.
    - → WAIT.
  - WAIT: hold core_din and core_decrypt; on core_done → CAPTURE.
  - CAPTURE (1 cycle):
    - result <= (dec&cbc_en) ? core_dout^chain : core_dout.
    - Chain update per the optional feature.
    - busy=0, done=1 → IDLE.
- Latency: start to done=1 is core latency + 3 cycles.
- core_done outside WAIT is ignored.
- cbc_en is sampled at start and held for the operation.
- result is stable until the next CAPTURE.

Optional Feature:
- Macro: AES_CHAIN_AUTO_EN.
- Defined: in CAPTURE with cbc_en=1:
  - Encrypt: chain <= core_dout.
  - Decrypt: chain <= src (received ciphertext).
  - Consecutive blocks continue the chain without rewriting the IV.
- Undefined: chain changes only via iv_wr; each block uses the last written IV.

Decomposition:
- Package aes_pkg holds:
  - BLK_W/WORD_W constants.
  - FSM state enum {IDLE, LAUNCH, WAIT, CAPTURE}.
  - Direction enum {DIR_ENC, DIR_DEC}.
- One sub-module, aes_word_packer: 4×32 shift-in register with write strobe.
  - Instantiated twice: input block and chain/IV.

Test Plan:
- Reset with busy=1 in WAIT:
  - All outputs are 0, FSM is IDLE.
  - A following core_done leaves result=0 and done=0.
- ECB encrypt:
  - cbc_en=0, write in_word 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, then start_enc.
  - core_din=0x00112233_44556677_8899AABB_CCDDEEFF and core_start pulses exactly 1 cycle.
  - Core model returning 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A yields that result and done=1 three cycles after the start beyond the core latency.
- CBC encrypt then decrypt:
  - IV = 0x000102030405060708090A0B0C0D0E0F.
  - Plaintext 0x6BC1BEE22E409F96E93D7E117393172A.
  - core_din = plaintext XOR IV = 0x6BC0BCE12A459991E134741A7F9E1925.
  - Rewrite the IV, decrypt the ciphertext: result equals the plaintext.
- Start conflicts:
  - start_enc and start_dec in the same cycle → core_decrypt=0.
  - Start with core_ready=0 → no core_start, busy stays 0.
  - start/in_wr during WAIT → no effect on in_blk or state.
- Packing boundary: 5 in_word writes 1..5 → in_blk = 0x00000002_00000003_00000004_00000005.
- AES_CHAIN_AUTO_EN:
  - Two consecutive CBC encrypts without an IV rewrite: the second core_din equals the second plaintext XOR the first result.
  - Macro undefined: the second core_din uses the IV.
